// File: rtl/arrow_lanes.sv
// rtl/arrow_lanes.sv - multi-lane rising arrow engine with hit/miss judging, scores and pixel flags
module arrow_lanes #(
    parameter int CORDW        = 10,
    parameter int LANES        = 4,
    parameter int SLOTS        = 4,
    parameter int ARROWX_BEGIN = 197,
    parameter int ARROWY_BEGIN = 450,
    parameter int ARROW_SIZE   = 50,
    parameter int ARROW_GAP    = 15,
    parameter int ARROW_SPEED  = 7,
    parameter int TARGET_Y     = 40,
    parameter int HIT_WINDOW   = 12,
    parameter int SCOREW       = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [CORDW-1:0]  sx_i,
    input  logic [CORDW-1:0]  sy_i,
    input  logic              frame_i,
    input  logic [LANES-1:0]  spawn_i,
    input  logic [LANES-1:0]  btn_i,
    output logic [LANES-1:0]  arrow_o,
    output logic [LANES-1:0]  full_o,
    output logic [LANES-1:0]  hit_o,
    output logic [LANES-1:0]  miss_o,
    output logic [SCOREW-1:0] score_o,
    output logic [SCOREW-1:0] misses_o
);

    localparam int SPACE = ARROW_SIZE + ARROW_GAP;
    localparam logic [CORDW-1:0] WIN_LO  = CORDW'(TARGET_Y - HIT_WINDOW);
    localparam logic [CORDW-1:0] WIN_HI  = CORDW'(TARGET_Y + HIT_WINDOW);
    localparam logic [CORDW-1:0] MISS_Y  = CORDW'(TARGET_Y - HIT_WINDOW + ARROW_SPEED);
    localparam logic [CORDW-1:0] SPAWN_Y = CORDW'(ARROWY_BEGIN);
    localparam logic [CORDW-1:0] SPEED   = CORDW'(ARROW_SPEED);

    logic [LANES-1:0][SLOTS-1:0]            valid_q, valid_n;
    logic [LANES-1:0][SLOTS-1:0][CORDW-1:0] y_q, y_n;
    logic [LANES-1:0] spawn_prev, btn_prev, spawn_rise, btn_rise;
    logic [LANES-1:0] hit_n, miss_n, full_n, draw_n;
    logic [SCOREW:0]  hit_cnt, miss_cnt, score_sum, misses_sum;
    logic             hit_found, spawn_found;

    assign spawn_rise = spawn_i & ~spawn_prev;
    assign btn_rise   = btn_i & ~btn_prev;

    // Hit, movement and spawn all judge the pre-update slot state, so a hit can
    // never claim a slot spawned in the same cycle and a fresh spawn never moves.
    always_comb begin
        valid_n     = valid_q;
        y_n         = y_q;
        hit_n       = '0;
        miss_n      = '0;
        full_n      = '0;
        hit_cnt     = '0;
        miss_cnt    = '0;
        hit_found   = 1'b0;
        spawn_found = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            hit_found   = 1'b0;
            spawn_found = 1'b0;
            for (int s = 0; s < SLOTS; s++) begin
                if (btn_rise[l] && !hit_found && valid_q[l][s] &&
                    y_q[l][s] >= WIN_LO && y_q[l][s] <= WIN_HI) begin
                    hit_found     = 1'b1;
                    valid_n[l][s] = 1'b0;
                    hit_n[l]      = 1'b1;
                end else if (frame_i && valid_q[l][s]) begin
                    if (y_q[l][s] < MISS_Y) begin
                        valid_n[l][s] = 1'b0;
                        miss_n[l]     = 1'b1;
                    end else begin
                        y_n[l][s] = y_q[l][s] - SPEED;
                    end
                end
                if (spawn_rise[l] && !spawn_found && !valid_q[l][s]) begin
                    spawn_found   = 1'b1;
                    valid_n[l][s] = 1'b1;
                    y_n[l][s]     = SPAWN_Y;
                end
            end
            full_n[l] = &valid_n[l];
            hit_cnt   = hit_cnt + (SCOREW+1)'(hit_n[l]);
            miss_cnt  = miss_cnt + (SCOREW+1)'(miss_n[l]);
        end
    end

    assign score_sum  = {1'b0, score_o} + hit_cnt;
    assign misses_sum = {1'b0, misses_o} + miss_cnt;

    always_comb begin
        draw_n = '0;
        for (int l = 0; l < LANES; l++) begin
            if (int'(sx_i) >= ARROWX_BEGIN + l*SPACE &&
                int'(sx_i) <  ARROWX_BEGIN + l*SPACE + ARROW_SIZE) begin
                for (int s = 0; s < SLOTS; s++) begin
                    if (valid_q[l][s] && int'(y_q[l][s]) <= int'(sy_i) &&
                        int'(sy_i) < int'(y_q[l][s]) + ARROW_SIZE)
                        draw_n[l] = 1'b1;
                end
            end
        end
    end

    // History regs reset high so inputs already asserted at reset release are not edges.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q    <= '0;
            y_q        <= '0;
            spawn_prev <= '1;
            btn_prev   <= '1;
            arrow_o    <= '0;
            full_o     <= '0;
            hit_o      <= '0;
            miss_o     <= '0;
            score_o    <= '0;
            misses_o   <= '0;
        end else begin
            valid_q    <= valid_n;
            y_q        <= y_n;
            spawn_prev <= spawn_i;
            btn_prev   <= btn_i;
            arrow_o    <= draw_n;
            full_o     <= full_n;
            hit_o      <= hit_n;
            miss_o     <= miss_n;
            score_o    <= score_sum[SCOREW] ? '1 : score_sum[SCOREW-1:0];
            misses_o   <= misses_sum[SCOREW] ? '1 : misses_sum[SCOREW-1:0];
        end
    end

endmodule

// File: tb/tb_arrow_lanes.sv
// tb/tb_arrow_lanes.sv - scoreboard bench for arrow_lanes
module tb_arrow_lanes;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [9:0] sx_i = '0;
    logic [9:0] sy_i = '0;
    logic       frame_i = 1'b0;
    logic [3:0] spawn_i = '0;
    logic [3:0] btn_i = '0;
    logic [3:0] arrow_o, full_o, hit_o, miss_o;
    logic [7:0] score_o, misses_o;

    int n_checks = 0;
    int n_pass   = 0;
    int score_m  = 0;
    string tag_q[$];
    int    exp_q[$];

    arrow_lanes dut (
        .clk_i(clk_i), .rst_i(rst_i), .sx_i(sx_i), .sy_i(sy_i),
        .frame_i(frame_i), .spawn_i(spawn_i), .btn_i(btn_i),
        .arrow_o(arrow_o), .full_o(full_o), .hit_o(hit_o), .miss_o(miss_o),
        .score_o(score_o), .misses_o(misses_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic sb_push(input string tag, input int exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic sb_pop(input int obs);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            string t;
            int e;
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            check(t, obs, e);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic spawn(input logic [3:0] m);
        spawn_i = m;
        cyc(1);
        spawn_i = '0;
        cyc(1);
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            frame_i = 1'b1;
            cyc(1);
            frame_i = 1'b0;
            cyc(1);
        end
    endtask

    task automatic frame_miss(input string tag, input int exp_miss, input int exp_cnt);
        sb_push({tag, "_miss"}, exp_miss);
        sb_push({tag, "_misses"}, exp_cnt);
        frame_i = 1'b1;
        cyc(1);
        sb_pop(int'(miss_o));
        sb_pop(int'(misses_o));
        frame_i = 1'b0;
        cyc(1);
    endtask

    task automatic press(input string tag, input logic [3:0] m, input int exp_hit, input int exp_score);
        sb_push({tag, "_hit"}, exp_hit);
        sb_push({tag, "_score"}, exp_score);
        btn_i = btn_i | m;
        cyc(1);
        sb_pop(int'(hit_o));
        sb_pop(int'(score_o));
        btn_i = btn_i & ~m;
        cyc(1);
    endtask

    task automatic probe(input string tag, input int x, input int y, input int exp);
        sb_push(tag, exp);
        sx_i = 10'(x);
        sy_i = 10'(y);
        cyc(1);
        sb_pop(int'(arrow_o));
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        // Lane 0 button held across reset release: must not count as a press.
        btn_i = 4'b0001;
        cyc(3);
        check("rst_arrow", int'(arrow_o), 0);
        check("rst_full", int'(full_o), 0);
        check("rst_score", int'(score_o), 0);
        check("rst_misses", int'(misses_o), 0);
        rst_i = 1'b0;
        cyc(2);
        check("held_btn_hit", int'(hit_o), 0);

        // T1 spawn and rise
        spawn(4'b0001);
        probe("t1_y450", 197, 450, 4'b0001);
        frames(1);
        probe("t1_y443", 197, 443, 4'b0001);
        probe("t1_y442", 197, 442, 4'b0000);
        frames(55);
        check("held_btn_score", int'(score_o), 0);

        // T2 early press at y=58, then good press at y=51
        btn_i = 4'b0000;
        cyc(1);
        press("t2_early", 4'b0001, 0, 0);
        probe("t2_y58", 197, 58, 4'b0001);
        frames(1);
        probe("t1_y51", 197, 51, 4'b0001);
        probe("t1_y50", 197, 50, 4'b0000);
        press("t2_hit", 4'b0001, 4'b0001, 1);
        probe("t2_empty", 197, 51, 4'b0000);

        // T3 miss after 61 frames
        spawn(4'b0001);
        frames(60);
        probe("t3_y30", 197, 30, 4'b0001);
        frame_miss("t3", 4'b0001, 1);
        probe("t3_freed", 197, 30, 4'b0000);

        // T4 fill lane 2, staggered by a frame each
        for (int i = 0; i < 4; i++) begin
            spawn(4'b0100);
            check($sformatf("t4_full_%0d", i), int'(full_o[2]), (i == 3) ? 1 : 0);
            frames(1);
        end
        spawn(4'b0100);
        check("t4_full_5", int'(full_o[2]), 1);
        probe("t4_drop", 327, 495, 4'b0000);
        probe("t4_y421", 327, 421, 4'b0000);
        probe("t4_y422", 327, 422, 4'b0100);
        probe("t4_y429", 327, 429, 4'b0100);
        probe("t4_y436", 327, 436, 4'b0100);

        // T5 draw bounds on lane 1
        spawn(4'b0010);
        probe("t5_in", 262, 450, 4'b0010);
        probe("t5_x312", 312, 450, 4'b0000);
        probe("t5_x311", 311, 450, 4'b0010);
        probe("t5_x261", 261, 450, 4'b0000);
        probe("t5_y499", 262, 499, 4'b0010);
        probe("t5_y500", 262, 500, 4'b0000);

        // T6 spawn and frame together: new arrow stays at spawn y
        spawn_i = 4'b1000;
        frame_i = 1'b1;
        cyc(1);
        spawn_i = '0;
        frame_i = 1'b0;
        cyc(1);
        probe("t6_spawnframe", 392, 450, 4'b1000);
        probe("t6_y449", 392, 449, 4'b0000);
        probe("t6_live", 392, 450, 4'b1000);
        check("t6_full_pre", int'(full_o), 4'b0100);

        // Asynchronous reset in mid-cycle
        #3;
        rst_i = 1'b1;
        #1;
        check("t6_rst_arrow", int'(arrow_o), 0);
        check("t6_rst_full", int'(full_o), 0);
        cyc(2);
        rst_i = 1'b0;
        cyc(1);
        probe("t6_rst_cleared", 392, 450, 4'b0000);

        // Four lanes hit per round until the score saturates
        score_m = 0;
        for (int r = 0; r < 65; r++) begin
            spawn(4'b1111);
            frames(57);
            score_m = (score_m + 4 > 255) ? 255 : score_m + 4;
            press($sformatf("sat_%0d", r), 4'b1111, 4'b1111, score_m);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
